// File: rtl/golden_nonce_tx_queue_pkg.sv
// golden_nonce_tx_queue_pkg: shared constants, nonce type and FSM encoding
package golden_nonce_tx_queue_pkg;
    localparam int NONCE_W = 32;
    localparam int NONCE_BYTES = 4;
    typedef logic [NONCE_W-1:0] nonce_t;
    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;
endpackage

// File: rtl/golden_nonce_tx_queue_if.sv
// golden_nonce_tx_queue_if: nonce input, UART byte handshake and queue status
interface golden_nonce_tx_queue_if #(parameter int DEPTH_LOG2 = 2);
    import golden_nonce_tx_queue_pkg::*;
    logic flush;
    logic nonce_valid;
    nonce_t nonce;
    logic tx_ready;
    logic tx_start;
    logic [7:0] tx_byte;
    logic [DEPTH_LOG2:0] queue_count;
    logic overflow;
    logic busy;
    modport master (output flush, nonce_valid, nonce, tx_ready,
                    input tx_start, tx_byte, queue_count, overflow, busy);
    modport slave (input flush, nonce_valid, nonce, tx_ready,
                   output tx_start, tx_byte, queue_count, overflow, busy);
endinterface

// File: rtl/golden_nonce_tx_queue_nonce_fifo.sv
// golden_nonce_tx_queue_nonce_fifo: first-word-fall-through nonce FIFO, push accepted when full if popping
module golden_nonce_tx_queue_nonce_fifo
    import golden_nonce_tx_queue_pkg::*;
#(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  logic pop,
    input  logic flush,
    input  nonce_t din,
    output nonce_t dout,
    output logic [DEPTH_LOG2:0] count,
    output logic full,
    output logic empty
);
    localparam int DEPTH = 1 << DEPTH_LOG2;
    nonce_t mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic do_pop, do_push;
    assign full = count == (DEPTH_LOG2+1)'(DEPTH);
    assign empty = count == '0;
    assign do_pop = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign dout = mem[rd_ptr];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
        end else begin
            wr_ptr <= wr_ptr + DEPTH_LOG2'(do_push);
            rd_ptr <= rd_ptr + DEPTH_LOG2'(do_pop);
            count <= count + (DEPTH_LOG2+1)'(do_push) - (DEPTH_LOG2+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= din;
    end
endmodule

// File: rtl/golden_nonce_tx_queue.sv
// golden_nonce_tx_queue: queues golden nonces and serializes each as 4 bytes to the UART
module golden_nonce_tx_queue
    import golden_nonce_tx_queue_pkg::*;
#(
    parameter int DEPTH_LOG2 = 2,
    parameter int LSB_FIRST = 1
) (
    input logic comm_clk,
    input logic reset_n,
    golden_nonce_tx_queue_if.slave bus
);
    state_t state, state_n;
    nonce_t sh, sh_n, head;
    logic [1:0] idx, idx_n;
    logic [7:0] tx_byte, byte_n;
    logic tx_start, start_n, overflow, overflow_n, busy, pop, full, empty;
    logic [DEPTH_LOG2:0] count;

    golden_nonce_tx_queue_nonce_fifo #(.DEPTH_LOG2(DEPTH_LOG2)) u_fifo (
        .clk(comm_clk),
        .rst_n(reset_n),
        .push(bus.nonce_valid & ~bus.flush),
        .pop(pop),
        .flush(bus.flush),
        .din(bus.nonce),
        .dout(head),
        .count(count),
        .full(full),
        .empty(empty)
    );

    always_comb begin
        state_n = state;
        sh_n = sh;
        idx_n = idx;
        start_n = 1'b0;
        byte_n = tx_byte;
        pop = 1'b0;
        case (state)
            IDLE: if (!empty && !bus.flush) begin
                pop = 1'b1;
                sh_n = head;
                idx_n = '0;
                state_n = SEND;
            end
            SEND: if (bus.tx_ready) begin
                start_n = 1'b1;
                byte_n = LSB_FIRST != 0 ? sh[7:0] : sh[NONCE_W-1 -: 8];
                sh_n = LSB_FIRST != 0 ? sh >> 8 : sh << 8;
                state_n = GAP;
            end
            GAP: begin
                // one dead cycle lets the UART drop tx_ready before it is looked at again
                state_n = idx == 2'(NONCE_BYTES-1) ? IDLE : SEND;
                idx_n = idx + 2'd1;
            end
            default: state_n = IDLE;
        endcase
        overflow_n = bus.flush ? 1'b0 : overflow | (bus.nonce_valid & full & ~pop);
    end

    always_ff @(posedge comm_clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            sh <= '0;
            idx <= '0;
            tx_start <= 1'b0;
            tx_byte <= '0;
            overflow <= 1'b0;
            busy <= 1'b0;
        end else begin
            state <= state_n;
            sh <= sh_n;
            idx <= idx_n;
            tx_start <= start_n;
            tx_byte <= byte_n;
            overflow <= overflow_n;
            busy <= state_n != IDLE;
        end
    end

    assign bus.tx_start = tx_start;
    assign bus.tx_byte = tx_byte;
    assign bus.queue_count = count;
    assign bus.overflow = overflow;
    assign bus.busy = busy;
endmodule

// File: doc/golden_nonce_tx_queue.md
Name: golden_nonce_tx_queue

Overview:
- Sits in the comm_clk domain, directly downstream of the miner's golden-nonce output, after the nonce and its strobe have been synchronized into comm_clk.
- Buffers found nonces in a small FIFO and serializes each one as 4 bytes onto the byte-wide UART transmitter handshake.
- Nonces found in quick succession are therefore not lost while the UART is busy.
- A flush input discards queued nonces when new work arrives.

Parameters:
DEPTH_LOG2, 2, log2 of FIFO depth in nonces (depth 4)
LSB_FIRST, 1, 1: nonce byte [7:0] sent first; 0: byte [31:24] sent first

Ports:
comm_clk  in  1  system/communication clock; all logic on rising edge
reset_n  in  1  reset, asynchronous assert, active-low
flush  in  1  one-cycle pulse on new work; empties the queue
nonce_valid  in  1  one-cycle pulse: nonce holds a new golden nonce
nonce  in  32  golden nonce value, sampled when nonce_valid=1
tx_ready  in  1  UART transmitter idle and able to take a byte
tx_start  out  1  one-cycle strobe: tx_byte is to be transmitted
tx_byte  out  8  byte for the UART transmitter, stable while tx_start=1
queue_count  out  DEPTH_LOG2+1  nonces currently queued, excluding the one in flight
overflow  out  1  sticky: a nonce was dropped because the queue was full
busy  out  1  high while a nonce is being serialized (state != IDLE)

Behaviour:
- Reset (reset_n=0, async) values: tx_start=0, tx_byte=0, queue_count=0, overflow=0, busy=0, state=IDLE, FIFO pointers=0.
- All outputs are registered.
- Push rules:
  - nonce_valid=1 with queue not full: nonce is written at that edge.
  - Full with no pop in the same cycle: the nonce is dropped and overflow is set to 1.
  - Full with a pop in the same cycle: the push is accepted and count stays at depth.
- FSM states:
  - IDLE: if queue non-empty, pop head into a 32-bit shift register, byte_idx=0, go to SEND.
  - SEND: when tx_ready=1, register tx_start=1 and tx_byte=current byte (LSB_FIRST selects shift direction), go to GAP; otherwise wait in SEND.
  - GAP: tx_start returns to 0 and tx_ready is ignored for this one cycle, so the transmitter's ready-drop is honoured. Then:
    - if byte_idx=3, go to IDLE;
    - else increment byte_idx and go to SEND.
- Latency:
  - With the queue empty, FSM IDLE and tx_ready=1, the first tx_start is high in the 3rd cycle after the nonce_valid cycle.
  - Bytes within one nonce are separated by at least 2 cycles.
  - A back-to-back queued nonce leaves IDLE on the cycle after GAP of byte 3.
- flush:
  - Clears the FIFO pointers and queue_count to 0 and clears overflow.
  - A nonce_valid in the same cycle as flush is dropped and does not set overflow; it belongs to the stale job.
  - A nonce already in the shift register finishes all 4 bytes. There is no mid-nonce abort, so host framing stays 4-byte aligned.
- tx_ready low for any duration holds the FSM in SEND without loss.
- Reset mid-nonce abandons the partial nonce; the host resynchronizes on the next job.
- queue_count never exceeds 2^DEPTH_LOG2 and pointers wrap modulo depth.

Decomposition:
- Shared package holds:
  - NONCE_BYTES=4;
  - the FSM state encoding (IDLE, SEND, GAP, 2-bit);
  - the nonce type width (32).
- One sub-module is natural: nonce_fifo, a synchronous FIFO with parameterized depth.
  - Ports: push, pop, flush, din, dout, count, full, empty.
  - Same-cycle push/pop allowed when full.
  - Asynchronous active-low reset.

Test Plan:
- After reset, nonce_valid with nonce=0x12345678 and tx_ready=1 → tx_start pulses carry 0x78, 0x56, 0x34, 0x12 in order; first pulse 3 cycles after the strobe; busy falls after the last byte.
- Same stimulus with LSB_FIRST=0 → bytes 0x12, 0x34, 0x56, 0x78.
- Hold tx_ready=0, then push 5 nonces A..E on consecutive cycles → A goes in flight and B..E fill the queue (queue_count=4), overflow stays 0. A 6th push F → dropped, overflow=1. Release tx_ready → 20 bytes are sent for A..E in order; F is never sent.
- Pulse flush while byte 1 of nonce A is pending, with 2 nonces queued → A's remaining 3 bytes are sent; queue_count=0 and overflow=0 next cycle; nothing further is transmitted.
- Pulse flush and nonce_valid in the same cycle → the nonce is not queued and queue_count=0.
- Pull reset_n low mid-byte while tx_ready is toggling → all outputs go to their reset values immediately (async); after release with no new nonce_valid, no tx_start occurs.
